// File: rtl/sim_net_pkg.sv
// Shared types for the simulated-network RX path.
//   NET_DATA_W / NET_KEEP_W : flit payload and byte-enable widths
//   net_flit_t              : one stored flit {data, keep, last}
//   rx_state_e              : input-side packet FSM states
package sim_net_pkg;

  localparam int unsigned NET_DATA_W = 64;
  localparam int unsigned NET_KEEP_W = NET_DATA_W / 8;

  typedef struct packed {
    logic [NET_DATA_W-1:0] data;
    logic [NET_KEEP_W-1:0] keep;
    logic                  last;
  } net_flit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sim_net_flit_ram.sv
// Flit storage: DEPTH x net_flit_t, one synchronous write port and one
// combinational read port (gives first-word fall-through at the output).
//   clock   : write clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_flit : flit to store
//   rd_addr : read index
//   rd_flit : flit at rd_addr (combinational)
module sim_net_flit_ram
  import sim_net_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  net_flit_t         wr_flit,
  input  logic [ADDR_W-1:0] rd_addr,
  output net_flit_t         rd_flit
);

  net_flit_t mem [DEPTH];

  // Storage is not reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_flit;
    end
  end

  assign rd_flit = mem[rd_addr];

endmodule

// File: rtl/sim_net_rx_buffer.sv
// Whole-packet RX buffer between the simulated network endpoint (no
// backpressure) and the NIC (ready/valid). Flits are written speculatively
// and only become visible once the packet's last flit is stored; a packet
// that runs out of space is dropped entirely.
//   clock, reset       : single clock, synchronous active-high reset
//   in_*               : endpoint RX stream (valid/data/keep/last)
//   out_*              : committed-packet stream to the NIC (ready/valid)
//   drop_pulse         : one-cycle pulse per dropped packet
//   drop_count         : saturating drop counter, present only when
//                        SIM_NET_RX_DROP_CNT_EN is defined
module sim_net_rx_buffer
  import sim_net_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = NET_DATA_W,
  parameter int unsigned KEEP_W = NET_KEEP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_bits_data,
  input  logic [KEEP_W-1:0] in_bits_keep,
  input  logic              in_bits_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_bits_data,
  output logic [KEEP_W-1:0] out_bits_keep,
  output logic              out_bits_last,
`ifdef SIM_NET_RX_DROP_CNT_EN
  output logic [31:0]       drop_count,
`endif
  output logic              drop_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  rx_state_e        state;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_commit;
  logic [PW-1:0]    wr_spec;
  logic [PW-1:0]    occupancy;
  logic             full;
  logic             wr_en_c;
  net_flit_t        wr_flit;
  net_flit_t        rd_flit;

  // Admission uses registered pointers only: a same-cycle read frees nothing.
  assign occupancy = wr_spec - rd_ptr;
  assign full      = (occupancy == PW'(DEPTH));
  assign wr_en_c   = in_valid && (state != DROP) && !full;

  assign wr_flit.data = in_bits_data;
  assign wr_flit.keep = in_bits_keep;
  assign wr_flit.last = in_bits_last;

  sim_net_flit_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en_c),
    .wr_addr (wr_spec[AW-1:0]),
    .wr_flit (wr_flit),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_flit (rd_flit)
  );

  // Output side only ever sees committed flits.
  assign out_valid     = (rd_ptr != wr_commit);
  assign out_bits_data = rd_flit.data;
  assign out_bits_keep = rd_flit.keep;
  assign out_bits_last = rd_flit.last;

  // Input FSM and pointer maintenance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_commit  <= '0;
      wr_spec    <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (out_valid && out_ready) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case (state)
        IDLE, RECV: begin
          if (in_valid) begin
            if (!full) begin
              wr_spec <= wr_spec + PW'(1);
              if (in_bits_last) begin
                wr_commit <= wr_spec + PW'(1);
                state     <= IDLE;
              end else begin
                state <= RECV;
              end
            end else begin
              // Rewind the speculative pointer: the partial packet vanishes.
              wr_spec    <= wr_commit;
              drop_pulse <= 1'b1;
              state      <= in_bits_last ? IDLE : DROP;
            end
          end
        end
        DROP: begin
          if (in_valid && in_bits_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIM_NET_RX_DROP_CNT_EN
  // Saturating count of dropped packets.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_pulse && (drop_count != 32'hFFFF_FFFF)) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sim_net_rx_buffer.sv
// Scoreboard bench for sim_net_rx_buffer (DEPTH=16): directed packets push
// expected flits; a monitor pops and compares on every output handshake.
module tb_sim_net_rx_buffer;
  import sim_net_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_bits_data;
  logic [7:0]  in_bits_keep;
  logic        in_bits_last;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_bits_data;
  logic [7:0]  out_bits_keep;
  logic        out_bits_last;
  logic        drop_pulse;
`ifdef SIM_NET_RX_DROP_CNT_EN
  logic [31:0] drop_count;
`endif

  sim_net_rx_buffer #(.DEPTH(16), .DATA_W(64), .KEEP_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_bits_data  (in_bits_data),
    .in_bits_keep  (in_bits_keep),
    .in_bits_last  (in_bits_last),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_bits_data (out_bits_data),
    .out_bits_keep (out_bits_keep),
    .out_bits_last (out_bits_last),
`ifdef SIM_NET_RX_DROP_CNT_EN
    .drop_count    (drop_count),
`endif
    .drop_pulse    (drop_pulse)
  );

  always #5 clock = ~clock;

  int        n_cmp = 0;
  int        n_err = 0;
  int        drops = 0;
  int        pops  = 0;
  bit        rand_ready = 1'b0;
  net_flit_t exp_q[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: compare every accepted output flit and count drop pulses.
  initial begin
    net_flit_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (drop_pulse) drops++;
        if (out_valid && out_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_flit: got data %0h with no flit expected", out_bits_data);
          end else begin
            e = exp_q.pop_front();
            check("flit_data", out_bits_data, e.data);
            check("flit_keep_last", 64'({out_bits_keep, out_bits_last}), 64'({e.keep, e.last}));
          end
        end
      end
    end
  end

  // Optional random backpressure, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Present one flit for exactly one rising edge; returns at edge + 1.
  task automatic drive_flit(input logic [63:0] d, input logic [7:0] k, input logic l);
    in_valid     = 1'b1;
    in_bits_data = d;
    in_bits_keep = k;
    in_bits_last = l;
    @(posedge clock);
    #1;
    in_valid     = 1'b0;
    in_bits_last = 1'b0;
  endtask

  function automatic net_flit_t mk_flit(input int id, input int idx, input int len);
    net_flit_t f;
    f.data = {16'hC0DE, 16'(id), 32'(idx)};
    f.last = (idx == len - 1);
    f.keep = f.last ? 8'(8'hFF >> (id % 8)) : 8'hFF;
    return f;
  endfunction

  task automatic send_pkt(input int id, input int len, input bit ok);
    net_flit_t f;
    for (int i = 0; i < len; i++) begin
      f = mk_flit(id, i, len);
      if (ok) exp_q.push_back(f);
      drive_flit(f.data, f.keep, f.last);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) idle(1);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    idle(1);
    check({name, "_valid_low"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int d0;
    int p0;
    net_flit_t f;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_bits_data = '0;
    in_bits_keep = '0;
    in_bits_last = 1'b0;
    out_ready    = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_drop_pulse", 64'(drop_pulse), 64'd0);

    // 1: 4-flit packet, out_valid rises only after the last flit's edge.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t1_valid_before_last", 64'(out_valid), 64'd0);
      f = mk_flit(1, i, 4);
      exp_q.push_back(f);
      drive_flit(f.data, f.keep, f.last);
    end
    check("t1_valid_after_last", 64'(out_valid), 64'd1);
    drain("t1");

    // 2: fill 16 flits with no readout, then a 3-flit packet is dropped.
    out_ready = 1'b0;
    d0 = drops;
    p0 = pops;
    for (int p = 0; p < 4; p++) send_pkt(10 + p, 4, 1'b1);
    check("t2_full_valid", 64'(out_valid), 64'd1);
    send_pkt(20, 3, 1'b0);
    idle(2);
    check("t2_drops", 64'(drops - d0), 64'd1);
    out_ready = 1'b1;
    drain("t2");
    check("t2_pops", 64'(pops - p0), 64'd16);

    // 3: oversize packet into an empty buffer is dropped, next one survives.
    d0 = drops;
    for (int i = 0; i < 20; i++) begin
      f = mk_flit(30, i, 20);
      drive_flit(f.data, f.keep, f.last);
      if (out_valid) check("t3_valid_during_oversize", 64'(out_valid), 64'd0);
    end
    idle(2);
    check("t3_valid_after_oversize", 64'(out_valid), 64'd0);
    check("t3_drops", 64'(drops - d0), 64'd1);
    send_pkt(31, 2, 1'b1);
    drain("t3");

    // 4: 100 single-flit packets with random backpressure; pointers wrap.
    d0 = drops;
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      send_pkt(100 + p, 1, 1'b1);
      idle(1);
    end
    rand_ready = 1'b0;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
    drain("t4");
    check("t4_drops", 64'(drops - d0), 64'd0);

    // 5: reset in the middle of a packet discards everything.
    out_ready = 1'b0;
    send_pkt(200, 2, 1'b0);
    check("t5_committed_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 2; i++) begin
      f = mk_flit(201, i, 5);
      drive_flit(f.data, f.keep, f.last);
    end
    d0 = drops;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t5_valid_after_reset", 64'(out_valid), 64'd0);
    check("t5_drop_pulse_after_reset", 64'(drop_pulse), 64'd0);
    out_ready = 1'b1;
    send_pkt(202, 3, 1'b1);
    drain("t5");
    check("t5_drops", 64'(drops - d0), 64'd0);

    // 6: three dropped packets behind a full buffer.
    out_ready = 1'b0;
    d0 = drops;
    for (int p = 0; p < 4; p++) send_pkt(300 + p, 4, 1'b1);
    for (int p = 0; p < 3; p++) send_pkt(310 + p, 2, 1'b0);
    idle(2);
    check("t6_drops", 64'(drops - d0), 64'd3);
`ifdef SIM_NET_RX_DROP_CNT_EN
    check("t6_drop_count", 64'(drop_count), 64'd3);
`endif
    out_ready = 1'b1;
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
